// File: rtl/adlif_pkg.sv
// Shared types, reset defaults and saturating arithmetic for the AdLIF step scheduler.
// The optional refractory feature is selected with the REFRACTORY_EN macro.
package adlif_pkg;

   localparam int unsigned FIX_W = 16;

   typedef logic signed [FIX_W-1:0] fix_t;

   localparam fix_t V_REST_DEF    = -16'sd17920;  // -70 mV in Q8.8
   localparam fix_t V_TH_BASE_DEF = -16'sd12800;  // -50 mV in Q8.8

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, NEXT} sched_state_e;

   // Signed add clamped to the range of a w-bit two's-complement value.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int unsigned w);
      logic signed [32:0] sum;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      sum = {a[31], a} + {b[31], b};
      hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo  = -(33'sd1 <<< (w - 1));
      if (sum > hi) begin
         return hi[31:0];
      end else if (sum < lo) begin
         return lo[31:0];
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/adlif_cur_accum.sv
// Double-buffered per-neuron current banks: saturating accumulate into ACC, sweep reads USE.
// A swap makes the old ACC the new USE and presents a cleared ACC in the same cycle.
module adlif_cur_accum
   import adlif_pkg::*;
#(
   parameter int unsigned N_NEURONS = 16,
   parameter int unsigned W         = FIX_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         swap,
   input  logic                         acc_valid,
   input  logic [$clog2(N_NEURONS)-1:0] acc_idx,
   input  logic signed [W-1:0]          acc_cur,
   input  logic [$clog2(N_NEURONS)-1:0] rd_idx,
   input  logic                         rd_clr,
   output logic signed [W-1:0]          rd_cur
);

   logic                 acc_sel_q, acc_sel_d;
   logic                 use_sel;
   logic signed [W-1:0]  bank_q [2][N_NEURONS];
   logic signed [W-1:0]  bank_d [2][N_NEURONS];

   assign use_sel = ~acc_sel_q;
   assign rd_cur  = bank_q[use_sel][rd_idx];

   always_comb begin
      bank_d    = bank_q;
      acc_sel_d = acc_sel_q;
      if (rd_clr) begin
         bank_d[use_sel][rd_idx] = '0;
      end
      if (swap) begin
         acc_sel_d = use_sel;
         for (int i = 0; i < N_NEURONS; i++) begin
            bank_d[use_sel][i] = '0;
         end
      end
      // Applied after the swap so a contribution in the swap cycle lands in the fresh ACC.
      if (acc_valid) begin
         bank_d[acc_sel_d][acc_idx] =
            W'(sat_add(32'(bank_d[acc_sel_d][acc_idx]), 32'(acc_cur), W));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_sel_q <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N_NEURONS; i++) begin
               bank_q[b][i] <= '0;
            end
         end
      end else begin
         acc_sel_q <= acc_sel_d;
         bank_q    <= bank_d;
      end
   end

endmodule

// File: rtl/adlif_step_scheduler.sv
// Sweeps N neurons through one shared AdLIF datapath per tick and emits spike events.
// Define REFRACTORY_EN to skip neurons for T_REFRAC ticks after they fire.
module adlif_step_scheduler
   import adlif_pkg::*;
#(
   parameter int unsigned N_NEURONS = 16,
   parameter int unsigned W         = FIX_W,
`ifdef REFRACTORY_EN
   parameter int unsigned T_REFRAC  = 3,
`endif
   parameter logic signed [W-1:0] V_REST    = V_REST_DEF,
   parameter logic signed [W-1:0] V_TH_BASE = V_TH_BASE_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         tick,
   output logic                         busy,
   output logic                         overrun,
   input  logic                         in_valid,
   input  logic [$clog2(N_NEURONS)-1:0] in_idx,
   input  logic signed [W-1:0]          in_cur,
   output logic                         upd_valid,
   input  logic                         upd_ready,
   output logic signed [W-1:0]          upd_v,
   output logic signed [W-1:0]          upd_th,
   output logic signed [W-1:0]          upd_i,
   output logic [$clog2(N_NEURONS)-1:0] upd_idx,
   input  logic                         res_valid,
   input  logic signed [W-1:0]          res_v,
   input  logic signed [W-1:0]          res_th,
   input  logic                         res_spike,
   output logic                         spk_valid,
   input  logic                         spk_ready,
   output logic [$clog2(N_NEURONS)-1:0] spk_idx
);

   localparam int unsigned IW = $clog2(N_NEURONS);
   localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

   sched_state_e        state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic signed [W-1:0] v_q  [N_NEURONS];
   logic signed [W-1:0] th_q [N_NEURONS];
   logic                swap, clr, wr_en, skip;

   adlif_cur_accum #(
      .N_NEURONS (N_NEURONS),
      .W         (W)
   ) u_cur_accum (
      .clk       (clk),
      .rst_n     (rst_n),
      .swap      (swap),
      .acc_valid (in_valid),
      .acc_idx   (in_idx),
      .acc_cur   (in_cur),
      .rd_idx    (idx_q),
      .rd_clr    (clr),
      .rd_cur    (upd_i)
   );

`ifdef REFRACTORY_EN
   localparam int unsigned RW = (T_REFRAC > 0) ? $clog2(T_REFRAC + 1) : 1;
   logic [RW-1:0] refrac_q [N_NEURONS];

   assign skip = (refrac_q[idx_q] != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            refrac_q[i] <= '0;
         end
      end else if (wr_en && res_spike) begin
         refrac_q[idx_q] <= RW'(T_REFRAC);
      end else if (state_q == ISSUE && skip) begin
         refrac_q[idx_q] <= refrac_q[idx_q] - 1'b1;
      end
   end
`else
   assign skip = 1'b0;
`endif

   assign busy    = (state_q != IDLE);
   assign upd_idx = idx_q;
   assign spk_idx = idx_q;
   assign upd_v   = v_q[idx_q];
   assign upd_th  = th_q[idx_q];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      upd_valid = 1'b0;
      spk_valid = 1'b0;
      swap      = 1'b0;
      clr       = 1'b0;
      wr_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               swap    = 1'b1;
               idx_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // A refractory neuron burns one cycle and drops its pending current.
            if (skip) begin
               clr     = 1'b1;
               state_d = NEXT;
            end else begin
               upd_valid = 1'b1;
               if (upd_ready) begin
                  clr     = 1'b1;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (res_valid) begin
               wr_en   = 1'b1;
               state_d = res_spike ? EMIT : NEXT;
            end
         end
         EMIT: begin
            spk_valid = 1'b1;
            if (spk_ready) begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            if (idx_q == LAST) begin
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         overrun <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            v_q[i]  <= V_REST;
            th_q[i] <= V_TH_BASE;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (tick && state_q != IDLE) begin
            overrun <= 1'b1;
         end
         if (wr_en) begin
            v_q[idx_q]  <= res_v;
            th_q[idx_q] <= res_th;
         end
      end
   end

endmodule

// File: tb/tb_adlif_step_scheduler.sv
// Directed bench for adlif_step_scheduler with a 1-cycle behavioural datapath (V+1mV, Vth+1 LSB).
// Refractory scenario runs only when REFRACTORY_EN is defined.
module tb_adlif_step_scheduler;

   localparam logic signed [15:0] VR  = -16'sd17920;
   localparam logic signed [15:0] VTH = -16'sd12800;

   logic clk, rst_n, tick, busy, overrun, in_valid, upd_valid, upd_ready;
   logic res_valid, res_spike, spk_valid, spk_ready;
   logic [3:0] in_idx, upd_idx, spk_idx;
   logic signed [15:0] in_cur, upd_v, upd_th, upd_i, res_v, res_th;

   int checks = 0;
   int failures = 0;

   int n_req, n_spk, busy_cyc, stall_req, last_res, end_cyc;
   bit timeout, aborted;
   int req_idx [64];
   logic signed [15:0] req_v [64];
   logic signed [15:0] req_th [64];
   logic signed [15:0] req_i [64];
   int spk_log [8];

   adlif_step_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .busy      (busy),
      .overrun   (overrun),
      .in_valid  (in_valid),
      .in_idx    (in_idx),
      .in_cur    (in_cur),
      .upd_valid (upd_valid),
      .upd_ready (upd_ready),
      .upd_v     (upd_v),
      .upd_th    (upd_th),
      .upd_i     (upd_i),
      .upd_idx   (upd_idx),
      .res_valid (res_valid),
      .res_v     (res_v),
      .res_th    (res_th),
      .res_spike (res_spike),
      .spk_valid (spk_valid),
      .spk_ready (spk_ready),
      .spk_idx   (spk_idx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic add_cur(input int idx, input logic signed [15:0] cur);
      @(negedge clk);
      in_valid = 1'b1;
      in_idx   = 4'(idx);
      in_cur   = cur;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Ticks once and serves the sweep; inj_cyc=-1 injects current in the tick cycle, -2 never.
   task automatic run_sweep(input logic [15:0] mask, input int stall, input int extra_tick,
                            input int abort_idx, input int inj_cyc, input int inj_idx,
                            input logic signed [15:0] inj_cur);
      int cyc, pidx, sc;
      bit pending;
      logic signed [15:0] pv, pth;
      n_req = 0; n_spk = 0; busy_cyc = 0; stall_req = 0; last_res = -1;
      timeout = 0; aborted = 0; pending = 0; sc = 0; pidx = 0; pv = '0; pth = '0;
      @(negedge clk);
      tick = 1'b1;
      if (inj_cyc == -1) begin
         in_valid = 1'b1; in_idx = 4'(inj_idx); in_cur = inj_cur;
      end
      @(negedge clk);
      tick = 1'b0;
      in_valid = 1'b0;
      cyc = 0;
      while (busy && cyc < 2000) begin
         busy_cyc++;
         res_valid = 1'b0; res_spike = 1'b0; spk_ready = 1'b0; tick = 1'b0; in_valid = 1'b0;
         if (pending) begin
            if (pidx == abort_idx) begin
               rst_n = 1'b0;
               aborted = 1;
               #1;
               return;
            end
            res_valid = 1'b1;
            res_v     = pv + 16'sd256;
            res_th    = pth + 16'sd1;
            res_spike = mask[pidx];
            pending   = 0;
            last_res  = cyc;
         end
         if (upd_valid && n_req < 64) begin
            req_idx[n_req] = int'(upd_idx);
            req_v[n_req]   = upd_v;
            req_th[n_req]  = upd_th;
            req_i[n_req]   = upd_i;
            n_req++;
            pending = 1;
            pidx = int'(upd_idx);
            pv = upd_v;
            pth = upd_th;
         end
         if (spk_valid) begin
            if (upd_valid) stall_req++;
            if (sc < stall) begin
               sc++;
            end else begin
               spk_ready = 1'b1;
               if (n_spk < 8) spk_log[n_spk] = int'(spk_idx);
               n_spk++;
               sc = 0;
            end
         end
         if (cyc == extra_tick) tick = 1'b1;
         if (cyc == inj_cyc) begin
            in_valid = 1'b1; in_idx = 4'(inj_idx); in_cur = inj_cur;
         end
         cyc++;
         @(negedge clk);
      end
      tick = 1'b0; res_valid = 1'b0; spk_ready = 1'b0; in_valid = 1'b0;
      timeout = (cyc >= 2000);
      end_cyc = cyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tick = 0; in_valid = 0; in_idx = '0; in_cur = '0; upd_ready = 1'b1;
      res_valid = 0; res_v = '0; res_th = '0; res_spike = 0; spk_ready = 0;
      #12;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
      checks++; if (upd_valid !== 1'b0) begin failures++; $display("FAIL reset_upd_valid got=%b want=0", upd_valid); end
      checks++; if (spk_valid !== 1'b0) begin failures++; $display("FAIL reset_spk_valid got=%b want=0", spk_valid); end
      checks++; if (upd_idx !== 4'd0 || spk_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d/%0d want=0/0", upd_idx, spk_idx); end
      checks++; if (upd_v !== VR || upd_th !== VTH) begin failures++; $display("FAIL reset_state got=%0d/%0d want=%0d/%0d", upd_v, upd_th, VR, VTH); end
      checks++; if (upd_i !== 16'sd0) begin failures++; $display("FAIL reset_cur got=%0d want=0", upd_i); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_sweep();
      int bad_order;
      run_sweep(16'h0000, 0, -1, -1, -2, 0, 16'sd0);
      bad_order = 0;
      for (int k = 0; k < 16; k++) if (req_idx[k] != k || req_v[k] !== VR) bad_order++;
      checks++; if (timeout) begin failures++; $display("FAIL sweep1_timeout got=1 want=0"); end
      checks++; if (n_req != 16) begin failures++; $display("FAIL sweep1_nreq got=%0d want=16", n_req); end
      checks++; if (bad_order != 0) begin failures++; $display("FAIL sweep1_order_v got=%0d bad want=0", bad_order); end
      checks++; if (n_spk != 0) begin failures++; $display("FAIL sweep1_spikes got=%0d want=0", n_spk); end
      checks++; if (busy_cyc != 48) begin failures++; $display("FAIL sweep1_cycles got=%0d want=48", busy_cyc); end
      checks++; if (end_cyc - last_res != 2) begin failures++; $display("FAIL sweep1_busy_drop got=%0d want=2", end_cyc - last_res); end
      run_sweep(16'h0000, 0, -1, -1, -2, 0, 16'sd0);
      checks++; if (req_v[0] !== -16'sd17664 || req_v[15] !== -16'sd17664) begin failures++; $display("FAIL sweep2_writeback_v got=%0d/%0d want=-17664", req_v[0], req_v[15]); end
      checks++; if (req_th[0] !== -16'sd12799) begin failures++; $display("FAIL sweep2_writeback_th got=%0d want=-12799", req_th[0]); end
   endtask

   task automatic test_accumulate();
      for (int k = 0; k < 3; k++) add_cur(5, 16'sd25600);
      for (int k = 0; k < 3; k++) add_cur(4, 16'sd2560);
      for (int k = 0; k < 2; k++) add_cur(6, -16'sd25600);
      for (int k = 0; k < 200; k++) add_cur(12, 16'sh7F00);
      run_sweep(16'h0000, 0, -1, -1, -1, 1, 16'sd512);
      checks++; if (req_i[5] !== 16'sd32767) begin failures++; $display("FAIL acc_sat_pos got=%0d want=32767", req_i[5]); end
      checks++; if (req_i[4] !== 16'sd7680) begin failures++; $display("FAIL acc_sum got=%0d want=7680", req_i[4]); end
      checks++; if (req_i[6] !== -16'sd32768) begin failures++; $display("FAIL acc_sat_neg got=%0d want=-32768", req_i[6]); end
      checks++; if (req_i[12] !== 16'sd32767) begin failures++; $display("FAIL acc_sat_many got=%0d want=32767", req_i[12]); end
      checks++; if (req_i[0] !== 16'sd0 || req_i[1] !== 16'sd0) begin failures++; $display("FAIL acc_untouched got=%0d/%0d want=0/0", req_i[0], req_i[1]); end
      run_sweep(16'h0000, 0, -1, -1, -2, 0, 16'sd0);
      checks++; if (req_i[5] !== 16'sd0) begin failures++; $display("FAIL acc_clear_on_use got=%0d want=0", req_i[5]); end
      checks++; if (req_i[1] !== 16'sd512) begin failures++; $display("FAIL acc_swap_cycle got=%0d want=512", req_i[1]); end
   endtask

   task automatic test_spike_stall();
      run_sweep(16'h0204, 10, -1, -1, -2, 0, 16'sd0);
      checks++; if (n_spk != 2) begin failures++; $display("FAIL spk_count got=%0d want=2", n_spk); end
      checks++; if (spk_log[0] != 2 || spk_log[1] != 9) begin failures++; $display("FAIL spk_order got=%0d,%0d want=2,9", spk_log[0], spk_log[1]); end
      checks++; if (stall_req != 0) begin failures++; $display("FAIL spk_req_in_stall got=%0d want=0", stall_req); end
      checks++; if (n_req != 16) begin failures++; $display("FAIL spk_nreq got=%0d want=16", n_req); end
      checks++; if (busy_cyc != 70) begin failures++; $display("FAIL spk_cycles got=%0d want=70", busy_cyc); end
   endtask

   task automatic test_overrun();
      do_reset();
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_initial got=%b want=0", overrun); end
      add_cur(3, 16'sd1280);
      run_sweep(16'h0000, 0, 5, -1, 8, 3, 16'sd1792);
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b want=1", overrun); end
      checks++; if (n_req != 16 || busy_cyc != 48) begin failures++; $display("FAIL ovr_sweep got=%0d/%0d want=16/48", n_req, busy_cyc); end
      checks++; if (req_i[3] !== 16'sd1280) begin failures++; $display("FAIL ovr_no_swap got=%0d want=1280", req_i[3]); end
      run_sweep(16'h0000, 0, -1, -1, -2, 0, 16'sd0);
      checks++; if (req_i[3] !== 16'sd1792 || req_i[10] !== 16'sd0) begin failures++; $display("FAIL ovr_next_bank got=%0d/%0d want=1792/0", req_i[3], req_i[10]); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
   endtask

   task automatic test_reset_mid_sweep();
      run_sweep(16'h0000, 0, -1, 7, -2, 0, 16'sd0);
      checks++; if (!aborted) begin failures++; $display("FAIL rst_mid_reached got=0 want=1"); end
      checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b/%b want=0/0", busy, overrun); end
      checks++; if (upd_valid !== 1'b0 || spk_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valids got=%b/%b want=0/0", upd_valid, spk_valid); end
      checks++; if (upd_idx !== 4'd0 || spk_idx !== 4'd0) begin failures++; $display("FAIL rst_mid_idx got=%0d/%0d want=0/0", upd_idx, spk_idx); end
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(16'h0000, 0, -1, -1, -2, 0, 16'sd0);
      checks++; if (n_req != 16 || req_idx[0] != 0) begin failures++; $display("FAIL rst_mid_restart got=%0d/%0d want=16/0", n_req, req_idx[0]); end
      checks++; if (req_v[0] !== VR || req_v[8] !== VR) begin failures++; $display("FAIL rst_mid_vrest got=%0d/%0d want=%0d", req_v[0], req_v[8], VR); end
   endtask

`ifdef REFRACTORY_EN
   task automatic test_refractory();
      do_reset();
      run_sweep(16'h0001, 0, -1, -1, -2, 0, 16'sd0);
      checks++; if (n_req != 16 || n_spk != 1) begin failures++; $display("FAIL ref_tick1 got=%0d/%0d want=16/1", n_req, n_spk); end
      for (int t = 2; t <= 4; t++) begin
         run_sweep(16'h0000, 0, -1, -1, -2, 0, 16'sd0);
         checks++; if (n_req != 15 || req_idx[0] != 1 || busy_cyc != 47) begin failures++; $display("FAIL ref_skip tick=%0d got=%0d/%0d/%0d want=15/1/47", t, n_req, req_idx[0], busy_cyc); end
      end
      run_sweep(16'h0000, 0, -1, -1, -2, 0, 16'sd0);
      checks++; if (n_req != 16 || req_idx[0] != 0) begin failures++; $display("FAIL ref_tick5 got=%0d/%0d want=16/0", n_req, req_idx[0]); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_sweep();
      test_accumulate();
      test_spike_stall();
      test_overrun();
      test_reset_mid_sweep();
`ifdef REFRACTORY_EN
      test_refractory();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
